// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller:
// MD op codes, FSM state codes and small op-decoding helpers.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'h0,
    MD_MULT  = 4'h1,
    MD_MTHI  = 4'h2,
    MD_MULTU = 4'h3,
    MD_MTLO  = 4'h4,
    MD_DIV   = 4'h5,
    MD_MFHI  = 4'h6,
    MD_DIVU  = 4'h7,
    MD_MFLO  = 4'h8
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE   = 2'd0,
    MDS_LAUNCH = 2'd1,
    MDS_BUSY   = 2'd2
  } md_state_e;

  // bit0 marks a mult/div start; bit2 picks divide among the starts
  function automatic logic md_is_start(input logic [3:0] op);
    return op[0];
  endfunction

  function automatic logic md_is_read(input logic [3:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// D->E issue controller for the HI/LO mult/div unit: issues start codes,
// tracks the in-flight op and stalls D on MD collisions. Optional: MD_WATCHDOG_EN.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [3:0] d_md_op,
  input  logic       ext_stall,
  input  logic       md_busy,
  output logic [3:0] md_start,
  output logic       md_rd,
  output logic       md_stall,
  output logic       md_err
);

  md_state_e state, state_nxt;
  logic      d_is_md;
  logic      issue;

  always_comb begin
    d_is_md  = d_valid && (d_md_op != MD_NONE);
    md_stall = d_is_md && (state != MDS_IDLE);
    issue    = d_is_md && !md_stall && !ext_stall;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MDS_IDLE:   if (issue && md_is_start(d_md_op)) state_nxt = MDS_LAUNCH;
      MDS_LAUNCH: state_nxt = MDS_BUSY;
      MDS_BUSY:   if (!md_busy) state_nxt = MDS_IDLE;
      default:    state_nxt = MDS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MDS_IDLE;
      md_start <= MD_NONE;
      md_rd    <= 1'b0;
    end else begin
      state    <= state_nxt;
      md_start <= issue ? d_md_op : MD_NONE;
      md_rd    <= issue && md_is_read(d_md_op);
    end
  end

`ifdef MD_WATCHDOG_EN
  localparam logic [4:0] WDT_LIM = 5'(WDT_LIMIT);

  logic [4:0] wdt_cnt;

  // cnt==1 in BUSY is exactly the cycle after LAUNCH, when the unit must be busy
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt <= '0;
      md_err  <= 1'b0;
    end else begin
      if (state == MDS_IDLE)
        wdt_cnt <= '0;
      else if (wdt_cnt != '1)
        wdt_cnt <= wdt_cnt + 5'd1;
      if ((wdt_cnt > WDT_LIM) ||
          ((state == MDS_BUSY) && (wdt_cnt == 5'd1) && !md_busy))
        md_err <= 1'b1;
    end
  end
`else
  assign md_err = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: behavioural HI/LO unit plus a
// rule-level reference model, directed scenarios then randomized traffic.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  localparam int unsigned LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [3:0] d_md_op = 4'h0;
  logic       ext_stall = 1'b0;
  logic       md_busy = 1'b0;
  logic [3:0] md_start;
  logic       md_rd, md_stall, md_err;

  md_issue_ctrl #(.WDT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_md_op(d_md_op),
    .ext_stall(ext_stall), .md_busy(md_busy), .md_start(md_start),
    .md_rd(md_rd), .md_stall(md_stall), .md_err(md_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // HI/LO unit model: busy 6 cycles after a mult, 11 after a div
  int busy_cnt = 0;
  bit hang = 0;
  bit ignore_start = 0;

  // reference: outstanding op = launch cycle, then wait until busy seen low
  bit         r_launch = 0, r_wait = 0, r_first = 0, r_rd = 0, r_err = 0;
  logic [3:0] r_start = 4'h0;
  int         r_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic ext, input logic rst);
    logic       pend, stall, issue, busy_pre;
    logic [3:0] start_pre;
    d_valid = v; d_md_op = op; ext_stall = ext; reset = rst;
    #1;
    pend  = r_launch || r_wait;
    stall = v && (op != 4'h0) && pend;
    check("md_stall", md_stall, stall);
    busy_pre  = md_busy;
    start_pre = md_start;
    @(posedge clk);
    #1;
    if (rst) busy_cnt = 0;
    else if (start_pre[0] && !ignore_start) busy_cnt = hang ? 30 : (start_pre[2] ? 11 : 6);
    else if (busy_cnt > 0) busy_cnt--;
    md_busy = (busy_cnt > 0);
    if (rst) begin
      r_launch = 0; r_wait = 0; r_first = 0; r_rd = 0; r_err = 0; r_start = 4'h0; r_cnt = 0;
    end else begin
      issue = v && (op != 4'h0) && !stall && !ext;
`ifdef MD_WATCHDOG_EN
      if (r_cnt > int'(LIMIT) || (r_first && !busy_pre)) r_err = 1;
      r_cnt = pend ? ((r_cnt < 31) ? r_cnt + 1 : 31) : 0;
`endif
      r_first  = r_launch;
      r_wait   = r_launch || (r_wait && busy_pre);
      r_launch = issue && op[0];
      r_start  = issue ? op : 4'h0;
      r_rd     = issue && (op == 4'h6 || op == 4'h8);
    end
    check("md_start", md_start, r_start);
    check("md_rd", md_rd, r_rd);
    check("md_err", md_err, r_err);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MD_NONE, 1'b0, 1'b0);
  endtask

  initial begin
    // initial reset without checks: the DUT is unknown before its first edge
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, MD_NONE, 1'b0, 1'b1);
    check("reset_start", md_start, 32'h0);
    check("reset_err", md_err, 32'h0);

    // MULT then MFLO waiting in D
    step(1'b1, MD_MULT, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, MD_MFLO, 1'b0, 1'b0);
      if (r_start == 4'h8) break;
    end
    idle_cycles(2);

    // DIV followed by non-MD traffic
    step(1'b1, MD_DIV, 1'b0, 1'b0);
    idle_cycles(14);

    // MULT then MULTU back-to-back
    step(1'b1, MD_MULT, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, MD_MULTU, 1'b0, 1'b0);
      if (r_start == 4'h3) break;
    end
    idle_cycles(10);

    // MTHI blocked by ext_stall for 2 cycles
    step(1'b1, MD_MTHI, 1'b1, 1'b0);
    step(1'b1, MD_MTHI, 1'b1, 1'b0);
    step(1'b1, MD_MTHI, 1'b0, 1'b0);
    step(1'b1, MD_MFHI, 1'b0, 1'b0);

    // reset in the third BUSY cycle of a DIV
    step(1'b1, MD_DIVU, 1'b0, 1'b0);
    idle_cycles(3);
    step(1'b0, MD_NONE, 1'b0, 1'b1);
    step(1'b1, MD_MFLO, 1'b0, 1'b0);
    idle_cycles(2);

    // unit hangs busy for 30 cycles
    hang = 1;
    step(1'b1, MD_MULT, 1'b0, 1'b0);
    idle_cycles(35);
    hang = 0;
    step(1'b0, MD_NONE, 1'b0, 1'b1);

    // unit ignores the start
    ignore_start = 1;
    step(1'b1, MD_DIV, 1'b0, 1'b0);
    idle_cycles(4);
    ignore_start = 0;
    step(1'b0, MD_NONE, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic       v, e, r;
      logic [3:0] op;
      v  = ($urandom_range(0, 9) < 7);
      op = 4'($urandom_range(0, 8));
      e  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(v, op, e, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
